// File: rtl/ppu_bus_bridge_pkg.sv
// ============================================================================
// Module   : ppu_bus_bridge_pkg
// Purpose  : Shared PPU register select encoding and bridge timing defaults.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ppu_bus_bridge_pkg;

  typedef enum logic [3:0] {
    PPUCTRL   = 4'd0,
    PPUMASK   = 4'd1,
    PPUSTATUS = 4'd2,
    OAMADDR   = 4'd3,
    OAMDATA   = 4'd4,
    PPUSCROLL = 4'd5,
    PPUADDR   = 4'd6,
    PPUDATA   = 4'd7,
    OAMDMA    = 4'd8
  } reg_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } bridge_state_t;

  localparam int c_cpu_div_dflt = 12;
  localparam int c_upd_dly_dflt = 11;

  function automatic logic reg_readable(input reg_t sel);
    return (sel == PPUSTATUS) || (sel == OAMDATA) || (sel == PPUDATA);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ppu_bus_bridge_addr_decode.sv
// ============================================================================
// Module   : ppu_addr_decode
// Purpose  : CPU address to PPU register select ($2000-$3FFF mirrored, $4014).
// Revision : 1.0
// ============================================================================
`default_nettype none

module ppu_addr_decode
  import ppu_bus_bridge_pkg::*;
(
  input  logic [15:0] i_addr,
  output logic        o_hit,
  output reg_t        o_sel,
  output logic        o_readable
);

  always_comb begin
    o_hit = 1'b0;
    o_sel = PPUCTRL;
    if (i_addr[15:13] == 3'b001) begin
      o_hit = 1'b1;
      o_sel = reg_t'({1'b0, i_addr[2:0]});
    end else if (i_addr == 16'h4014) begin
      o_hit = 1'b1;
      o_sel = OAMDMA;
    end
    o_readable = o_hit && reg_readable(o_sel);
  end

endmodule

`default_nettype wire

// File: rtl/ppu_bus_bridge.sv
// ============================================================================
// Module   : ppu_bus_bridge
// Purpose  : CPU bus front end of the PPU registers: decode, hold, read capture,
//            open-bus latch, OAMDMA stall and CPU cycle parity.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ppu_bus_bridge
  import ppu_bus_bridge_pkg::*;
#(
  parameter int CPU_DIV = c_cpu_div_dflt,
  parameter int UPD_DLY = c_upd_dly_dflt
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_clk_en,
  input  logic [15:0] bus_addr,
  input  logic        bus_re,
  input  logic        bus_we,
  input  logic [7:0]  bus_wr_data,
  output logic [7:0]  bus_rd_data,
  output logic        bus_rd_valid,
  output logic        bus_hit,
  output reg_t        reg_sel,
  output logic        reg_en,
  output logic        reg_rw,
  output logic [7:0]  reg_data_in,
  input  logic [7:0]  reg_data_out,
  input  logic        cpu_sus,
  output logic        cpu_stall,
  output logic        cpu_cyc_par
);

  localparam int c_tap = UPD_DLY + 1;

  // Capture may land at most one clock past the following CPU strobe.
  if (UPD_DLY + 1 > CPU_DIV) begin : g_dly_check
    $error("ppu_bus_bridge: UPD_DLY too large for CPU_DIV");
  end

  logic          w_dec_hit;
  reg_t          w_dec_sel;
  logic          w_dec_rd;
  logic          w_access;
  logic          w_issue_rd;
  logic          w_cap;
  logic          w_en_nxt;
  logic          w_hit_nxt;
  bridge_state_t r_state;
  bridge_state_t w_state_nxt;
  logic          r_stall;
  logic [c_tap:0] r_rd_pipe;
  logic [c_tap:0] r_rdok_pipe;

  ppu_addr_decode u_decode (
    .i_addr     (bus_addr),
    .o_hit      (w_dec_hit),
    .o_sel      (w_dec_sel),
    .o_readable (w_dec_rd)
  );

  assign w_access   = cpu_clk_en && !r_stall && w_dec_hit && (bus_re || bus_we);
  assign w_issue_rd = w_access && !bus_we;
  assign w_cap      = r_rd_pipe[c_tap];
  assign cpu_stall  = r_stall;

  always_comb begin
    w_state_nxt = r_state;
    w_en_nxt    = reg_en;
    w_hit_nxt   = bus_hit;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          w_state_nxt = ST_ACTIVE;
          w_en_nxt    = bus_we || w_dec_rd;
          w_hit_nxt   = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_access) begin
          w_state_nxt = ST_ACTIVE;
          w_en_nxt    = bus_we || w_dec_rd;
          w_hit_nxt   = 1'b1;
        end else if (cpu_clk_en) begin
          w_state_nxt = ST_IDLE;
          w_en_nxt    = 1'b0;
          w_hit_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_en_nxt    = 1'b0;
        w_hit_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      reg_en  <= 1'b0;
      bus_hit <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      reg_en  <= w_en_nxt;
      bus_hit <= w_hit_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_sel     <= PPUCTRL;
      reg_rw      <= 1'b0;
      reg_data_in <= 8'h00;
    end else if (w_access) begin
      reg_sel     <= w_dec_sel;
      reg_rw      <= bus_we;
      reg_data_in <= bus_wr_data;
    end
  end

  // Read timing is a tap line so a capture survives the next strobe re-latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pipe   <= '0;
      r_rdok_pipe <= '0;
    end else begin
      r_rd_pipe   <= {r_rd_pipe[c_tap-1:0], w_issue_rd};
      r_rdok_pipe <= {r_rdok_pipe[c_tap-1:0], w_issue_rd && w_dec_rd};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_rd_data  <= 8'h00;
      bus_rd_valid <= 1'b0;
    end else begin
      bus_rd_valid <= w_cap;
      if (w_access && bus_we) begin
        bus_rd_data <= bus_wr_data;
      end else if (w_cap && r_rdok_pipe[c_tap]) begin
        bus_rd_data <= reg_data_out;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall     <= 1'b0;
      cpu_cyc_par <= 1'b0;
    end else begin
      r_stall <= cpu_sus;
      if (cpu_clk_en) begin
        cpu_cyc_par <= ~cpu_cyc_par;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ppu_bus_bridge.sv
// ============================================================================
// Module   : tb_ppu_bus_bridge
// Purpose  : Directed self-checking bench for ppu_bus_bridge.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ppu_bus_bridge;
  import ppu_bus_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_clk_en;
  logic [15:0] bus_addr;
  logic        bus_re;
  logic        bus_we;
  logic [7:0]  bus_wr_data;
  logic [7:0]  bus_rd_data;
  logic        bus_rd_valid;
  logic        bus_hit;
  reg_t        reg_sel;
  logic        reg_en;
  logic        reg_rw;
  logic [7:0]  reg_data_in;
  logic [7:0]  reg_data_out;
  logic        cpu_sus;
  logic        cpu_stall;
  logic        cpu_cyc_par;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int strobe_cyc = 0;
  int rd_cyc = 0;
  int last_valid_cyc = 0;
  int valid_cnt = 0;
  int en_cnt = 0;
  int par_tog = 0;
  logic par_prev = 1'b0;

  ppu_bus_bridge dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_clk_en   (cpu_clk_en),
    .bus_addr     (bus_addr),
    .bus_re       (bus_re),
    .bus_we       (bus_we),
    .bus_wr_data  (bus_wr_data),
    .bus_rd_data  (bus_rd_data),
    .bus_rd_valid (bus_rd_valid),
    .bus_hit      (bus_hit),
    .reg_sel      (reg_sel),
    .reg_en       (reg_en),
    .reg_rw       (reg_rw),
    .reg_data_in  (reg_data_in),
    .reg_data_out (reg_data_out),
    .cpu_sus      (cpu_sus),
    .cpu_stall    (cpu_stall),
    .cpu_cyc_par  (cpu_cyc_par)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (bus_rd_valid === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      last_valid_cyc = cyc;
    end
    if (reg_en === 1'b1) en_cnt = en_cnt + 1;
    if (cpu_cyc_par !== par_prev) par_tog = par_tog + 1;
    par_prev = cpu_cyc_par;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [15:0] a, input logic re, input logic we, input logic [7:0] d);
    bus_addr    = a;
    bus_re      = re;
    bus_we      = we;
    bus_wr_data = d;
    cpu_clk_en  = 1'b1;
    @(negedge clk);
    strobe_cyc = cyc;
    cpu_clk_en = 1'b0;
    bus_re     = 1'b0;
    bus_we     = 1'b0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_reg_en"},  32'(reg_en),       32'h0);
    check({pfx, "_reg_sel"}, 32'(reg_sel),      32'(PPUCTRL));
    check({pfx, "_reg_rw"},  32'(reg_rw),       32'h0);
    check({pfx, "_data_in"}, 32'(reg_data_in),  32'h0);
    check({pfx, "_rd_data"}, 32'(bus_rd_data),  32'h0);
    check({pfx, "_rd_vld"},  32'(bus_rd_valid), 32'h0);
    check({pfx, "_hit"},     32'(bus_hit),      32'h0);
    check({pfx, "_stall"},   32'(cpu_stall),    32'h0);
    check({pfx, "_par"},     32'(cpu_cyc_par),  32'h0);
  endtask

  initial begin
    rst_n        = 1'b0;
    cpu_clk_en   = 1'b0;
    bus_addr     = 16'h0000;
    bus_re       = 1'b0;
    bus_we       = 1'b0;
    bus_wr_data  = 8'h00;
    reg_data_out = 8'h00;
    cpu_sus      = 1'b0;

    wait_clk(3);
    check_reset("rst");
    rst_n = 1'b1;
    wait_clk(2);

    // Write $2000 = 0x80
    en_cnt = 0;
    strobe(16'h2000, 1'b0, 1'b1, 8'h80);
    check("wr_sel",     32'(reg_sel),     32'(PPUCTRL));
    check("wr_rw",      32'(reg_rw),      32'h1);
    check("wr_data_in", 32'(reg_data_in), 32'h80);
    check("wr_en",      32'(reg_en),      32'h1);
    check("wr_hit",     32'(bus_hit),     32'h1);
    check("wr_openbus", 32'(bus_rd_data), 32'h80);
    wait_clk(11);
    strobe(16'h0000, 1'b0, 1'b0, 8'h00);
    check("wr_en_drop", 32'(reg_en),  32'h0);
    check("wr_en_len",  32'(en_cnt),  32'd12);
    check("wr_hit_drop", 32'(bus_hit), 32'h0);

    // Read $3FFA (PPUSTATUS mirror), data presented late at +12
    wait_clk(11);
    reg_data_out = 8'h55;
    valid_cnt = 0;
    strobe(16'h3FFA, 1'b1, 1'b0, 8'h00);
    rd_cyc = strobe_cyc;
    check("rd_sel", 32'(reg_sel),      32'(PPUSTATUS));
    check("rd_rw",  32'(reg_rw),       32'h0);
    check("rd_en",  32'(reg_en),       32'h1);
    check("rd_vld_early", 32'(bus_rd_valid), 32'h0);
    wait_clk(11);
    strobe(16'h0000, 1'b0, 1'b0, 8'h00);
    check("rd_no_vld_yet", 32'(valid_cnt), 32'd0);
    reg_data_out = 8'hC0;
    wait_clk(4);
    check("rd_vld_cnt", 32'(valid_cnt), 32'd1);
    check("rd_latency", 32'(last_valid_cyc - rd_cyc), 32'd13);
    check("rd_data",    32'(bus_rd_data), 32'hC0);

    // Write $2005 = 0x12, then read write-only $2000
    wait_clk(7);
    strobe(16'h2005, 1'b0, 1'b1, 8'h12);
    check("wo_wr_data", 32'(bus_rd_data), 32'h12);
    check("wo_wr_sel",  32'(reg_sel),     32'(PPUSCROLL));
    wait_clk(11);
    reg_data_out = 8'h77;
    valid_cnt = 0;
    strobe(16'h2000, 1'b1, 1'b0, 8'h00);
    rd_cyc = strobe_cyc;
    check("wo_rd_en",  32'(reg_en),  32'h0);
    check("wo_rd_hit", 32'(bus_hit), 32'h1);
    check("wo_rd_rw",  32'(reg_rw),  32'h0);
    wait_clk(11);
    strobe(16'h0000, 1'b0, 1'b0, 8'h00);
    wait_clk(4);
    check("wo_vld_cnt", 32'(valid_cnt), 32'd1);
    check("wo_latency", 32'(last_valid_cyc - rd_cyc), 32'd13);
    check("wo_openbus", 32'(bus_rd_data), 32'h12);

    // Back-to-back writes $2006 = 0x3F, 0x00
    wait_clk(7);
    en_cnt = 0;
    strobe(16'h2006, 1'b0, 1'b1, 8'h3F);
    wait_clk(11);
    check("b2b_data_first", 32'(reg_data_in), 32'h3F);
    strobe(16'h2006, 1'b0, 1'b1, 8'h00);
    check("b2b_data_second", 32'(reg_data_in), 32'h00);
    check("b2b_en_mid",      32'(reg_en),      32'h1);
    wait_clk(11);
    strobe(16'h0000, 1'b0, 1'b0, 8'h00);
    check("b2b_en_len",  32'(en_cnt),      32'd24);
    check("b2b_en_drop", 32'(reg_en),      32'h0);
    check("b2b_openbus", 32'(bus_rd_data), 32'h00);

    // OAMDMA write then 514 stalled strobes
    wait_clk(11);
    strobe(16'h4014, 1'b0, 1'b1, 8'h02);
    check("dma_sel", 32'(reg_sel),     32'(OAMDMA));
    check("dma_en",  32'(reg_en),      32'h1);
    check("dma_ob",  32'(bus_rd_data), 32'h02);
    cpu_sus = 1'b1;
    wait_clk(2);
    check("dma_stall",   32'(cpu_stall), 32'h1);
    check("dma_en_hold", 32'(reg_en),    32'h1);
    wait_clk(9);
    par_tog = 0;
    valid_cnt = 0;
    strobe(16'h2000, 1'b0, 1'b1, 8'hFF);
    check("stall_en_drop", 32'(reg_en), 32'h0);
    en_cnt = 0;
    wait_clk(11);
    repeat (513) begin
      strobe(16'h2000, 1'b0, 1'b1, 8'hFF);
      wait_clk(11);
    end
    check("stall_par_tog", 32'(par_tog),     32'd514);
    check("stall_en_cnt",  32'(en_cnt),      32'd0);
    check("stall_hit",     32'(bus_hit),     32'h0);
    check("stall_ob",      32'(bus_rd_data), 32'h02);
    check("stall_vld",     32'(valid_cnt),   32'd0);
    cpu_sus = 1'b0;
    wait_clk(2);
    check("unstall", 32'(cpu_stall), 32'h0);
    wait_clk(9);
    strobe(16'h2001, 1'b0, 1'b1, 8'h5A);
    check("post_sel", 32'(reg_sel),     32'(PPUMASK));
    check("post_en",  32'(reg_en),      32'h1);
    check("post_ob",  32'(bus_rd_data), 32'h5A);

    // Read of $4014 and a non-PPU write
    wait_clk(11);
    strobe(16'h4014, 1'b1, 1'b0, 8'h00);
    check("dma_rd_hit", 32'(bus_hit), 32'h1);
    check("dma_rd_en",  32'(reg_en),  32'h0);
    wait_clk(11);
    strobe(16'h4000, 1'b0, 1'b1, 8'h33);
    check("miss_hit", 32'(bus_hit),     32'h0);
    check("miss_ob",  32'(bus_rd_data), 32'h5A);

    // Reset in the middle of a PPUDATA read
    wait_clk(11);
    strobe(16'h2007, 1'b1, 1'b0, 8'h00);
    check("pd_sel", 32'(reg_sel), 32'(PPUDATA));
    check("pd_en",  32'(reg_en),  32'h1);
    wait_clk(4);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("mid_rst");
    @(negedge clk);
    valid_cnt = 0;
    rst_n = 1'b1;
    wait_clk(20);
    check("mid_rst_no_vld", 32'(valid_cnt),   32'd0);
    check("mid_rst_ob",     32'(bus_rd_data), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
